// File: rtl/kws_pkg.sv
// rtl/kws_pkg.sv - shared types, limits and width helper for kernel_window_scanner
//
// Purpose: scanner state encoding, largest legal window side, and the
//          accumulator width function used by the top and the MAC.
// Contents: state_e (ST_IDLE/ST_SCAN/ST_DONE), SIZE_MAX, acc_w().

package kws_pkg;

  localparam int SIZE_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Room for the full product plus headroom for summing size*size terms.
  function automatic int acc_w(input int size, input int data_w);
    return 2 * data_w + $clog2(size * size);
  endfunction

endpackage

// File: rtl/kws_mac.sv
// rtl/kws_mac.sv - unsigned multiply-accumulate for the window scanner
//
// Purpose: sums a_i*b_i on every enabled cycle; clear_i wins over en_i.
// Ports:
//   clk, n_rst     - clock, asynchronous active-low reset
//   clear_i        - zero the accumulator
//   en_i           - add the current product
//   a_i, b_i       - unsigned operands, DATA_W bits
//   acc_o          - running sum, ACC_W bits

module kws_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [ACC_W-1:0]  acc_o
);

  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    acc_d;
  logic [2*DATA_W-1:0] prod;

  assign prod = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + {{(ACC_W - 2 * DATA_W){1'b0}}, prod};
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/kernel_window_scanner.sv
// rtl/kernel_window_scanner.sv - streams a snapshotted SIZExSIZE window beat by beat
//
// Purpose: on start, captures the pixel and kernel windows and emits one
//          beat per (x,y) position, y inner, with valid/ready flow control.
//          Optional MAC (macro KWS_MAC_EN) sums pixel*kernel over the scan.
// Ports:
//   clk, n_rst            - clock, asynchronous active-low reset
//   start, abort          - begin a scan (IDLE only), cancel a scan (SCAN only)
//   kernel, in            - coefficient / pixel windows indexed [x][y]
//   out_ready             - downstream accepts the current beat
//   out_valid             - beat outputs valid (exactly while scanning)
//   pixel_v, kernel_v     - snapshot elements at [cur_x][cur_y]
//   cur_x, cur_y, last    - beat position, final-beat flag
//   busy, done            - scan or completion active, one-cycle done pulse
//   acc_out, acc_valid    - MAC sum and its valid flag (zero without KWS_MAC_EN)

module kernel_window_scanner
  import kws_pkg::*;
#(
  parameter logic [3:0] SIZE   = 4'd3,
  parameter int         DATA_W = 8
) (
  input  logic                                  clk,
  input  logic                                  n_rst,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] kernel,
  input  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] in,
  input  logic                                  out_ready,
  output logic                                  out_valid,
  output logic [DATA_W-1:0]                     pixel_v,
  output logic [DATA_W-1:0]                     kernel_v,
  output logic [3:0]                            cur_x,
  output logic [3:0]                            cur_y,
  output logic                                  last,
  output logic                                  busy,
  output logic                                  done,
  output logic [acc_w(int'(SIZE), DATA_W)-1:0]  acc_out,
  output logic                                  acc_valid
);

  localparam int         N        = int'(SIZE);
  localparam logic [3:0] LAST_IDX = SIZE - 4'd1;

  typedef logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] window_t;

  state_e            state_q, state_d;
  window_t           psnap_q, psnap_d;
  window_t           ksnap_q, ksnap_d;
  logic [3:0]        cur_x_q, cur_x_d;
  logic [3:0]        cur_y_q, cur_y_d;
  logic [DATA_W-1:0] pix_q, pix_d;
  logic [DATA_W-1:0] ker_q, ker_d;
  logic              last_q, last_d;

  logic              start_acc;
  logic              fire;
  logic [3:0]        nx, ny;
  logic [DATA_W-1:0] pix_next, ker_next;

  assign start_acc = (state_q == ST_IDLE) && start;
  // abort outranks a handshake, including the one on the final beat
  assign fire      = (state_q == ST_SCAN) && out_ready && !abort;

  always_comb begin
    if (cur_y_q == LAST_IDX) begin
      nx = cur_x_q + 4'd1;
      ny = 4'd0;
    end else begin
      nx = cur_x_q;
      ny = cur_y_q + 4'd1;
    end
  end

  // Explicit compare-select keeps the 4-bit counters away from narrower array indices.
  always_comb begin
    pix_next = '0;
    ker_next = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (4'(i) == nx && 4'(j) == ny) begin
          pix_next = psnap_q[i][j];
          ker_next = ksnap_q[i][j];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    psnap_d = psnap_q;
    ksnap_d = ksnap_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    pix_d   = pix_q;
    ker_d   = ker_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          state_d = ST_SCAN;
          psnap_d = in;
          ksnap_d = kernel;
          cur_x_d = 4'd0;
          cur_y_d = 4'd0;
          pix_d   = in[0][0];
          ker_d   = kernel[0][0];
          last_d  = 1'b0;
        end
      end
      ST_SCAN: begin
        if (abort) begin
          state_d = ST_IDLE;
          last_d  = 1'b0;
        end else if (fire) begin
          if (last_q) begin
            state_d = ST_DONE;
            last_d  = 1'b0;
          end else begin
            cur_x_d = nx;
            cur_y_d = ny;
            pix_d   = pix_next;
            ker_d   = ker_next;
            last_d  = (nx == LAST_IDX) && (ny == LAST_IDX);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      psnap_q <= '0;
      ksnap_q <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      pix_q   <= '0;
      ker_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      psnap_q <= psnap_d;
      ksnap_q <= ksnap_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      pix_q   <= pix_d;
      ker_q   <= ker_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = (state_q == ST_SCAN);
  assign busy      = (state_q == ST_SCAN) || (state_q == ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign pixel_v   = pix_q;
  assign kernel_v  = ker_q;
  assign cur_x     = cur_x_q;
  assign cur_y     = cur_y_q;
  assign last      = last_q;

`ifdef KWS_MAC_EN
  localparam int ACC_W = acc_w(N, DATA_W);

  kws_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear_i (start_acc),
    .en_i    (fire),
    .a_i     (pix_q),
    .b_i     (ker_q),
    .acc_o   (acc_out)
  );

  assign acc_valid = (state_q == ST_DONE);
`else
  assign acc_out   = '0;
  assign acc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_kernel_window_scanner.sv
// tb/tb_kernel_window_scanner.sv - directed self-checking bench for kernel_window_scanner

module tb_kernel_window_scanner;

`ifdef KWS_MAC_EN
  localparam bit MAC_ON = 1'b1;
`else
  localparam bit MAC_ON = 1'b0;
`endif

  logic clk;
  logic n_rst;

  // SIZE=3 instance
  logic                 start3, abort3, ready3;
  logic [2:0][2:0][7:0] in3, ker3;
  logic                 valid3, last3, busy3, done3, accv3;
  logic [7:0]           pix3, kv3;
  logic [3:0]           cx3, cy3;
  logic [19:0]          acc3;

  // SIZE=4 instance
  logic                 start4, abort4, ready4;
  logic [3:0][3:0][7:0] in4, ker4;
  logic                 valid4, last4, busy4, done4, accv4;
  logic [7:0]           pix4, kv4;
  logic [3:0]           cx4, cy4;
  logic [19:0]          acc4;

  int n_cmp = 0;
  int n_err = 0;
  int exp_pix[9];
  int exp_ker[9];
  int beats;

  kernel_window_scanner #(.SIZE(4'd3), .DATA_W(8)) dut3 (
    .clk(clk), .n_rst(n_rst), .start(start3), .abort(abort3),
    .kernel(ker3), .in(in3), .out_ready(ready3),
    .out_valid(valid3), .pixel_v(pix3), .kernel_v(kv3),
    .cur_x(cx3), .cur_y(cy3), .last(last3), .busy(busy3), .done(done3),
    .acc_out(acc3), .acc_valid(accv3)
  );

  kernel_window_scanner #(.SIZE(4'd4), .DATA_W(8)) dut4 (
    .clk(clk), .n_rst(n_rst), .start(start4), .abort(abort4),
    .kernel(ker4), .in(in4), .out_ready(ready4),
    .out_valid(valid4), .pixel_v(pix4), .kernel_v(kv4),
    .cur_x(cx4), .cur_y(cy4), .last(last4), .busy(busy4), .done(done4),
    .acc_out(acc4), .acc_valid(accv4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pattern3();
    for (int x = 0; x < 3; x++)
      for (int y = 0; y < 3; y++) begin
        in3[x][y]  = 8'(3 * x + y + 1);
        ker3[x][y] = 8'd1;
        exp_pix[3 * x + y] = 3 * x + y + 1;
        exp_ker[3 * x + y] = 1;
      end
  endtask

  // Call with start3 already high; consumes beats until out_valid drops.
  // stall_at: beat index held with out_ready=0 for 4 cycles.
  // change_at: beat index on which inputs are scrambled and start re-pulsed.
  task automatic scan3(input int stall_at, input int change_at, output int nb);
    int stall;
    stall = 0;
    nb = 0;
    step();
    start3 = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (!valid3) break;
      if (nb >= 9) begin
        check("beat_overrun", nb, 8);
        break;
      end
      check("pix3", pix3, exp_pix[nb]);
      check("ker3", kv3, exp_ker[nb]);
      check("cx3", cx3, nb / 3);
      check("cy3", cy3, nb % 3);
      check("last3", last3, (nb == 8) ? 1 : 0);
      start3 = 1'b0;
      if (nb == change_at) begin
        in3 = {9{8'hAA}};
        ker3 = {9{8'h02}};
        start3 = 1'b1;
      end
      if (nb == stall_at && stall < 4) begin
        ready3 = 1'b0;
        stall++;
      end else begin
        ready3 = 1'b1;
        nb++;
      end
      step();
    end
    start3 = 1'b0;
    ready3 = 1'b1;
  endtask

  initial begin
    n_rst = 1'b0;
    start3 = 0; abort3 = 0; ready3 = 1; in3 = '0; ker3 = '0;
    start4 = 0; abort4 = 0; ready4 = 1; in4 = '0; ker4 = '0;
    #2;
    check("rst_valid", valid3, 0);
    check("rst_busy", busy3, 0);
    check("rst_done", done3, 0);
    check("rst_pix", pix3, 0);
    check("rst_acc", acc3, 0);
    step();
    n_rst = 1'b1;
    step();

    // Basic scan: pixels 1..9, done after last, sum 45.
    load_pattern3();
    start3 = 1'b1;
    scan3(-1, -1, beats);
    check("t1_beats", beats, 9);
    check("t1_done", done3, 1);
    check("t1_busy_done", busy3, 1);
    check("t1_valid_done", valid3, 0);
    check("t1_accv", accv3, MAC_ON ? 1 : 0);
    check("t1_acc", acc3, MAC_ON ? 45 : 0);
    step();
    check("t1_done_off", done3, 0);
    check("t1_busy_off", busy3, 0);
    check("t1_accv_off", accv3, 0);
    step();
    check("t1_acc_hold", acc3, MAC_ON ? 45 : 0);

    // Back-pressure on beat (1,1).
    start3 = 1'b1;
    scan3(4, -1, beats);
    check("t2_beats", beats, 9);
    check("t2_done", done3, 1);
    step();

    // Inputs change and start re-pulses mid-scan; snapshot must be used.
    load_pattern3();
    start3 = 1'b1;
    scan3(-1, 2, beats);
    check("t3_beats", beats, 9);
    check("t3_done", done3, 1);
    check("t3_acc", acc3, MAC_ON ? 45 : 0);
    step();
    check("t3_no_restart", valid3, 0);
    step();
    check("t3_still_idle", valid3, 0);

    // Abort on beat (0,2).
    load_pattern3();
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    step();
    step();
    check("t4_cy", cy3, 2);
    check("t4_valid_before", valid3, 1);
    abort3 = 1'b1;
    step();
    abort3 = 1'b0;
    check("t4_valid", valid3, 0);
    check("t4_busy", busy3, 0);
    check("t4_done", done3, 0);
    check("t4_accv", accv3, 0);
    step();
    check("t4_done_later", done3, 0);

    // Abort coinciding with the final handshake.
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    for (int k = 0; k < 8; k++) step();
    check("t4b_last", last3, 1);
    abort3 = 1'b1;
    step();
    abort3 = 1'b0;
    check("t4b_done", done3, 0);
    check("t4b_valid", valid3, 0);
    check("t4b_accv", accv3, 0);

    // Fresh start after abort still works.
    start3 = 1'b1;
    scan3(-1, -1, beats);
    check("t4c_beats", beats, 9);
    check("t4c_done", done3, 1);
    check("t4c_acc", acc3, MAC_ON ? 45 : 0);
    step();

    // Reset mid-scan: asynchronous clear.
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    step();
    step();
    step();
    #1;
    n_rst = 1'b0;
    #1;
    check("t5_valid", valid3, 0);
    check("t5_pix", pix3, 0);
    check("t5_ker", kv3, 0);
    check("t5_cx", cx3, 0);
    check("t5_cy", cy3, 0);
    check("t5_busy", busy3, 0);
    check("t5_acc", acc3, 0);
    #1;
    n_rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t5_idle_valid", valid3, 0);
    end
    start3 = 1'b1;
    scan3(-1, -1, beats);
    check("t5_beats", beats, 9);
    step();

    // SIZE=4, saturating values, 16 beats, sum 8160.
    in4 = {16{8'd255}};
    ker4 = {16{8'd2}};
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    beats = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (!valid4 || beats >= 16) break;
      check("t6_pix", pix4, 255);
      check("t6_pos", {cx4, cy4}, {4'(beats / 4), 4'(beats % 4)});
      check("t6_last", last4, (beats == 15) ? 1 : 0);
      beats++;
      step();
    end
    check("t6_beats", beats, 16);
    check("t6_done", done4, 1);
    check("t6_acc", acc4, MAC_ON ? 8160 : 0);
    check("t6_accv", accv4, MAC_ON ? 1 : 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
